// File: rtl/mcu.sv
// rtl/mcu.sv - hardwired multi-cycle control unit for the single-bus MIPS-subset CPU
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   Zero            ALU result==0 from the datapath (examined at the end of B1)
//   IR_out[31:0]    instruction register; opcode [31:26] dispatched in D0, funct [5:0] used in R1/R2
//   PC*, A*, IRWr   PC source/drive/write, A register write/drive, IR write
//   ALUOp, ExtSel   ALU operation and immediate-unit mode
//   *Oe             internal bus drivers (at most one high per cycle)
//   RegWr, RegDst   register-file write and destination select (0 rt / 1 rd)
//   Dir, Mem*, MDR* memory bus direction/strobes and MDR control, MARWr loads MAR
module mcu (
  input  logic        clk,
  input  logic        rst,
  input  logic        Zero,
  input  logic [31:0] IR_out,
  output logic        PCSrc,
  output logic        PCOe,
  output logic        PCWr,
  output logic [1:0]  ALUOp,
  output logic        AWr,
  output logic        AOe,
  output logic        IRWr,
  output logic [1:0]  ExtSel,
  output logic        ImmOe,
  output logic        RegWr,
  output logic        Reg1Oe,
  output logic        Reg2Oe,
  output logic        GOe,
  output logic        Dir,
  output logic        MemOe,
  output logic        MDRSrc,
  output logic        MDROe,
  output logic        MDRWr,
  output logic        MemRd,
  output logic        MemWr,
  output logic        MARWr,
  output logic        RegDst
);

  typedef enum logic [4:0] {
    F0, F1, F2, D0,
    L0, L1, L2, L3, L4,
    S0, S1, S2, S3, S4,
    R0, R1, R2,
    B0, B1, B2, B3, B4,
    I0, I1, I2,
    O0, O1, O2,
    J0
  } state_t;

  state_t state, next;

  logic [5:0] op, funct;
  logic [1:0] r_aluop;
  logic       r_known;
  logic       unused_ir;

  assign op        = IR_out[31:26];
  assign funct     = IR_out[5:0];
  assign unused_ir = ^IR_out[25:6];

  // R-type funct decode; unsupported functs compute an add but never write back.
  always_comb begin
    r_aluop = 2'b00;
    r_known = 1'b1;
    case (funct)
      6'h20:   r_aluop = 2'b00;
      6'h22:   r_aluop = 2'b01;
      6'h24:   r_aluop = 2'b10;
      6'h25:   r_aluop = 2'b11;
      default: r_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= F0;
    else     state <= next;
  end

  always_comb begin
    next = F0;
    case (state)
      F0: next = F1;
      F1: next = F2;
      F2: next = D0;
      D0: begin
        case (op)
          6'h23:   next = L0;
          6'h2B:   next = S0;
          6'h00:   next = R0;
          6'h04:   next = B0;
          6'h08:   next = I0;
          6'h0D:   next = O0;
          6'h02:   next = J0;
          default: next = F0;
        endcase
      end
      L0: next = L1;
      L1: next = L2;
      L2: next = L3;
      L3: next = L4;
      S0: next = S1;
      S1: next = S2;
      S2: next = S3;
      S3: next = S4;
      R0: next = R1;
      R1: next = R2;
      B0: next = B1;
      B1: next = Zero ? B2 : F0;  // Zero reflects rs - rt computed in this cycle
      B2: next = B3;
      B3: next = B4;
      I0: next = I1;
      I1: next = I2;
      O0: next = O1;
      O1: next = O2;
      default: next = F0;
    endcase
  end

  always_comb begin
    PCSrc = 1'b0; PCOe = 1'b0; PCWr = 1'b0; ALUOp = 2'b00; AWr = 1'b0;
    AOe = 1'b0; IRWr = 1'b0; ExtSel = 2'b00; ImmOe = 1'b0; RegWr = 1'b0;
    Reg1Oe = 1'b0; Reg2Oe = 1'b0; GOe = 1'b0; Dir = 1'b0; MemOe = 1'b0;
    MDRSrc = 1'b0; MDROe = 1'b0; MDRWr = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
    MARWr = 1'b0; RegDst = 1'b0;
    // Reset silences every strobe, including the state an aborted instruction was in.
    if (!rst) begin
      case (state)
        F0: begin PCOe = 1'b1; MARWr = 1'b1; end
        F1: begin
          MemRd = 1'b1; MemOe = 1'b1; MDRSrc = 1'b1; MDRWr = 1'b1; PCWr = 1'b1;
        end
        F2: begin MDROe = 1'b1; IRWr = 1'b1; end
        L0, S0, R0, B0, I0, O0: begin Reg1Oe = 1'b1; AWr = 1'b1; end
        L1, S1, I1: begin ImmOe = 1'b1; ExtSel = 2'b01; end
        O1: begin ImmOe = 1'b1; ExtSel = 2'b00; ALUOp = 2'b11; end
        L2, S2: begin GOe = 1'b1; MARWr = 1'b1; end
        L3: begin MemRd = 1'b1; MemOe = 1'b1; MDRSrc = 1'b1; MDRWr = 1'b1; end
        L4: begin MDROe = 1'b1; RegWr = 1'b1; end
        S3: begin Reg2Oe = 1'b1; MDRWr = 1'b1; end
        S4: begin MemWr = 1'b1; Dir = 1'b1; end
        R1: begin Reg2Oe = 1'b1; ALUOp = r_aluop; end
        R2: begin GOe = 1'b1; RegDst = 1'b1; RegWr = r_known; end
        B1: begin Reg2Oe = 1'b1; ALUOp = 2'b01; end
        B2: begin PCOe = 1'b1; AWr = 1'b1; end
        B3: begin ImmOe = 1'b1; ExtSel = 2'b10; end
        B4: begin GOe = 1'b1; PCSrc = 1'b1; PCWr = 1'b1; end
        I2, O2: begin GOe = 1'b1; RegWr = 1'b1; end
        J0: begin ImmOe = 1'b1; ExtSel = 2'b11; PCSrc = 1'b1; PCWr = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu.sv
// tb/tb_mcu.sv - scoreboard bench for mcu against a register-transfer model
module tb_mcu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Zero = 1'b0;
  logic [31:0] IR_out = 32'h0;
  logic        PCSrc, PCOe, PCWr, AWr, AOe, IRWr, ImmOe, RegWr, Reg1Oe, Reg2Oe, GOe;
  logic        Dir, MemOe, MDRSrc, MDROe, MDRWr, MemRd, MemWr, MARWr, RegDst;
  logic [1:0]  ALUOp, ExtSel;

  always #5 clk = ~clk;

  mcu dut (
    .clk(clk), .rst(rst), .Zero(Zero), .IR_out(IR_out),
    .PCSrc(PCSrc), .PCOe(PCOe), .PCWr(PCWr), .ALUOp(ALUOp), .AWr(AWr), .AOe(AOe),
    .IRWr(IRWr), .ExtSel(ExtSel), .ImmOe(ImmOe), .RegWr(RegWr), .Reg1Oe(Reg1Oe),
    .Reg2Oe(Reg2Oe), .GOe(GOe), .Dir(Dir), .MemOe(MemOe), .MDRSrc(MDRSrc),
    .MDROe(MDROe), .MDRWr(MDRWr), .MemRd(MemRd), .MemWr(MemWr), .MARWr(MARWr),
    .RegDst(RegDst)
  );

  typedef struct packed {
    logic       pc_src, pc_oe, pc_wr;
    logic [1:0] alu_op;
    logic       a_wr, a_oe, ir_wr;
    logic [1:0] ext_sel;
    logic       imm_oe, reg_wr, reg1_oe, reg2_oe, g_oe, dir, mem_oe;
    logic       mdr_src, mdr_oe, mdr_wr, mem_rd, mem_wr, mar_wr, reg_dst;
  } ctl_t;

  typedef enum int {SRC_NONE, SRC_PC, SRC_IMM, SRC_RS, SRC_RT, SRC_G, SRC_MDR} src_e;

  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_AND = 2'd2, ALU_OR = 2'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_BR = 2'd2, EXT_J = 2'd3;

  ctl_t plan[$];
  ctl_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // One bus transfer: who drives the internal bus this cycle.
  function automatic ctl_t xfer(input src_e s);
    ctl_t c = '0;
    case (s)
      SRC_PC:  c.pc_oe   = 1'b1;
      SRC_IMM: c.imm_oe  = 1'b1;
      SRC_RS:  c.reg1_oe = 1'b1;
      SRC_RT:  c.reg2_oe = 1'b1;
      SRC_G:   c.g_oe    = 1'b1;
      SRC_MDR: c.mdr_oe  = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t mem_to_mdr();
    ctl_t c = '0;
    c.mem_rd = 1'b1; c.mem_oe = 1'b1; c.dir = 1'b0; c.mdr_src = 1'b1; c.mdr_wr = 1'b1;
    return c;
  endfunction

  function automatic ctl_t alu_with(input src_e s, input logic [1:0] op, input logic [1:0] ext);
    ctl_t c = xfer(s);
    c.alu_op = op;
    if (s == SRC_IMM) c.ext_sel = ext;
    return c;
  endfunction

  // Expected control vector for every cycle of one instruction, given a constant Zero.
  task automatic build(input logic [31:0] ir, input logic z);
    ctl_t c;
    logic [5:0] op, f;
    logic [1:0] rop;
    logic known;
    op = ir[31:26];
    f  = ir[5:0];
    plan.delete();
    c = xfer(SRC_PC);  c.mar_wr = 1'b1; plan.push_back(c);
    c = mem_to_mdr();  c.pc_wr = 1'b1;  plan.push_back(c);
    c = xfer(SRC_MDR); c.ir_wr = 1'b1;  plan.push_back(c);
    plan.push_back(ctl_t'(0));
    case (op)
      6'h23, 6'h2B: begin
        c = xfer(SRC_RS); c.a_wr = 1'b1; plan.push_back(c);
        plan.push_back(alu_with(SRC_IMM, ALU_ADD, EXT_SIGN));
        c = xfer(SRC_G); c.mar_wr = 1'b1; plan.push_back(c);
        if (op == 6'h23) begin
          plan.push_back(mem_to_mdr());
          c = xfer(SRC_MDR); c.reg_wr = 1'b1; plan.push_back(c);
        end else begin
          c = xfer(SRC_RT); c.mdr_wr = 1'b1; plan.push_back(c);
          c = '0; c.mem_wr = 1'b1; c.dir = 1'b1; plan.push_back(c);
        end
      end
      6'h00: begin
        known = 1'b1;
        case (f)
          6'h20:   rop = ALU_ADD;
          6'h22:   rop = ALU_SUB;
          6'h24:   rop = ALU_AND;
          6'h25:   rop = ALU_OR;
          default: begin rop = ALU_ADD; known = 1'b0; end
        endcase
        c = xfer(SRC_RS); c.a_wr = 1'b1; plan.push_back(c);
        plan.push_back(alu_with(SRC_RT, rop, EXT_ZERO));
        c = xfer(SRC_G); c.reg_dst = 1'b1; c.reg_wr = known; plan.push_back(c);
      end
      6'h04: begin
        c = xfer(SRC_RS); c.a_wr = 1'b1; plan.push_back(c);
        plan.push_back(alu_with(SRC_RT, ALU_SUB, EXT_ZERO));
        if (z) begin
          c = xfer(SRC_PC); c.a_wr = 1'b1; plan.push_back(c);
          plan.push_back(alu_with(SRC_IMM, ALU_ADD, EXT_BR));
          c = xfer(SRC_G); c.pc_src = 1'b1; c.pc_wr = 1'b1; plan.push_back(c);
        end
      end
      6'h08, 6'h0D: begin
        c = xfer(SRC_RS); c.a_wr = 1'b1; plan.push_back(c);
        if (op == 6'h08) plan.push_back(alu_with(SRC_IMM, ALU_ADD, EXT_SIGN));
        else             plan.push_back(alu_with(SRC_IMM, ALU_OR, EXT_ZERO));
        c = xfer(SRC_G); c.reg_wr = 1'b1; plan.push_back(c);
      end
      6'h02: begin
        c = alu_with(SRC_IMM, ALU_ADD, EXT_J); c.pc_src = 1'b1; c.pc_wr = 1'b1;
        plan.push_back(c);
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_len(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycles: got %0d expected %0d", name, got, want);
    end
  endtask

  // Issue an instruction; cut>0 truncates it (used to abort with reset).
  task automatic run_instr(input logic [31:0] ir, input logic z, input int cut);
    int n;
    IR_out = ir;
    Zero   = z;
    build(ir, z);
    n = (cut > 0 && cut < plan.size()) ? cut : plan.size();
    for (int i = 0; i < n; i++) exp_q.push_back(plan[i]);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ctl_t'(0));
      tick();
    end
    rst = 1'b0;
  endtask

  // Monitor: every cycle compares the DUT against the oldest pending expectation.
  initial begin
    ctl_t act, exp_c;
    int drivers;
    forever begin
      @(negedge clk);
      cyc++;
      act = '0;
      act.pc_src = PCSrc; act.pc_oe = PCOe; act.pc_wr = PCWr; act.alu_op = ALUOp;
      act.a_wr = AWr; act.a_oe = AOe; act.ir_wr = IRWr; act.ext_sel = ExtSel;
      act.imm_oe = ImmOe; act.reg_wr = RegWr; act.reg1_oe = Reg1Oe; act.reg2_oe = Reg2Oe;
      act.g_oe = GOe; act.dir = Dir; act.mem_oe = MemOe; act.mdr_src = MDRSrc;
      act.mdr_oe = MDROe; act.mdr_wr = MDRWr; act.mem_rd = MemRd; act.mem_wr = MemWr;
      act.mar_wr = MARWr; act.reg_dst = RegDst;
      if (exp_q.size() > 0) begin
        exp_c = exp_q.pop_front();
        checks++;
        if (act !== exp_c) begin
          errors++;
          $display("FAIL ctl cycle %0d ir=%h: got %h expected %h", cyc, IR_out, act, exp_c);
        end
      end
      drivers = int'(PCOe) + int'(AOe) + int'(ImmOe) + int'(Reg1Oe) + int'(Reg2Oe)
              + int'(GOe) + int'(MDROe);
      checks++;
      if (drivers > 1) begin
        errors++;
        $display("FAIL bus_onehot cycle %0d: got %0d drivers expected <=1", cyc, drivers);
      end
    end
  end

  initial begin
    logic [31:0] r, ir;
    logic [5:0]  op;
    int budget;
    tick();
    do_reset(2);

    run_instr(32'h8C010001, 1'b0, 0);
    expect_len("lw", plan.size(), 9);
    run_instr(32'hAC220004, 1'b0, 0);
    expect_len("sw", plan.size(), 9);
    run_instr(32'h00221822, 1'b0, 0);
    expect_len("sub", plan.size(), 7);
    run_instr(32'h0022183F, 1'b0, 0);
    run_instr(32'h10220003, 1'b1, 0);
    expect_len("beq_taken", plan.size(), 9);
    run_instr(32'h10220003, 1'b0, 0);
    expect_len("beq_not", plan.size(), 6);
    run_instr(32'h08000010, 1'b0, 0);
    expect_len("j", plan.size(), 5);
    run_instr(32'hFC000000, 1'b0, 0);
    run_instr(32'h20410005, 1'b0, 0);
    run_instr(32'h3441F00F, 1'b1, 0);

    // Abort lw in L3: issue F0..L2, then reset while L3 is current.
    run_instr(32'h8C010001, 1'b0, 7);
    do_reset(2);
    run_instr(32'h00221825, 1'b1, 0);

    for (int k = 0; k < 300; k++) begin
      r = $urandom();
      case ($urandom_range(0, 7))
        0: op = 6'h23;
        1: op = 6'h2B;
        2: op = 6'h00;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h0D;
        6: op = 6'h02;
        default: begin
          op = r[31:26];
          while (op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h0D, 6'h02})
            op = 6'($urandom_range(0, 63));
        end
      endcase
      ir = {op, r[25:0]};
      if (op == 6'h00 && r[31]) begin
        case (r[30:29])
          2'd0: ir[5:0] = 6'h20;
          2'd1: ir[5:0] = 6'h22;
          2'd2: ir[5:0] = 6'h24;
          default: ir[5:0] = 6'h25;
        endcase
      end
      run_instr(ir, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 19) == 0) begin
        run_instr(ir, 1'b0, int'($urandom_range(1, 6)));
        do_reset(1);
      end
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
